// File: rtl/branch_target_predictor_pkg.sv
// Shared types and helpers for the fetch-side branch predictor (BTB + 2-bit PHT).
// Optional gshare indexing is enabled by defining BP_GSHARE_EN.
package branch_target_predictor_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_ctr_t;

    // Tag is kept at full upper-PC width so the entry type is independent of BTB depth.
    typedef struct packed {
        logic        valid;
        logic        is_jump;
        logic [29:0] tag;
        logic [31:0] target;
    } btb_entry_t;

    function automatic logic [29:0] pc_tag(input logic [31:0] pc, input int idx_w);
        return 30'(pc >> (idx_w + 2));
    endfunction

    function automatic bp_ctr_t ctr_next(input bp_ctr_t c, input logic taken);
        bp_ctr_t n;
        n = c;
        case (c)
            SNT: n = taken ? WNT : SNT;
            WNT: n = taken ? WT  : SNT;
            WT:  n = taken ? ST  : WNT;
            ST:  n = taken ? ST  : WT;
            default: n = WNT;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/branch_target_predictor_if.sv
// Lookup and training bus between the fetch/execute pipeline (master) and the predictor (slave).
interface branch_target_predictor_if;
    logic [31:0] if_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_is_jump;
    logic        upd_taken;
    logic [31:0] upd_target;

    modport master (
        output if_pc, upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target,
        input  pred_hit, pred_taken, pred_target
    );

    modport slave (
        input  if_pc, upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target,
        output pred_hit, pred_taken, pred_target
    );
endinterface

// File: rtl/branch_target_predictor_pht.sv
// Pattern history table of 2-bit saturating counters, bimodal or gshare (`BP_GSHARE_EN).
// Read is combinational from registered state; update lands on the clock edge.
module bp_pht
    import branch_target_predictor_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int GHR_W   = 6,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_pc_idx_i,
    input  logic             upd_en_i,
    input  logic [IDX_W-1:0] upd_pc_idx_i,
    input  logic             upd_taken_i,
    output bp_ctr_t          rd_ctr_o
);

    bp_ctr_t          pht_q [ENTRIES];
    logic [IDX_W-1:0] rd_p;
    logic [IDX_W-1:0] upd_p;
    bp_ctr_t          upd_ctr_d;

`ifdef BP_GSHARE_EN
    logic [GHR_W-1:0] ghr_q;
    logic [GHR_W-1:0] ghr_d;

    assign rd_p  = rd_pc_idx_i  ^ IDX_W'(ghr_q);
    assign upd_p = upd_pc_idx_i ^ IDX_W'(ghr_q);
    assign ghr_d = GHR_W'({ghr_q, upd_taken_i});

    // History is non-speculative: it only moves when a conditional branch resolves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_q <= '0;
        end else if (upd_en_i) begin
            ghr_q <= ghr_d;
        end
    end
`else
    assign rd_p  = rd_pc_idx_i;
    assign upd_p = upd_pc_idx_i;
`endif

    assign rd_ctr_o  = pht_q[rd_p];
    assign upd_ctr_d = ctr_next(pht_q[upd_p], upd_taken_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                pht_q[i] <= WNT;
            end
        end else if (upd_en_i) begin
            pht_q[upd_p] <= upd_ctr_d;
        end
    end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit PHT; zero-latency lookup of if_pc, trained by EX outcomes.
// Gshare PHT indexing is selected by defining BP_GSHARE_EN (default: bimodal).
module branch_target_predictor
    import branch_target_predictor_pkg::*;
#(
    parameter int BTB_ENTRIES = 64,
    parameter int GHR_W       = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    branch_target_predictor_if.slave  bp
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);

    btb_entry_t       btb_q [BTB_ENTRIES];
    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] upd_idx;
    btb_entry_t       lk_ent;
    btb_entry_t       upd_ent;
    btb_entry_t       upd_ent_d;
    logic             upd_hit;
    logic             upd_we;
    bp_ctr_t          lk_ctr;

    assign lk_idx  = bp.if_pc[IDX_W+1:2];
    assign upd_idx = bp.upd_pc[IDX_W+1:2];
    assign lk_ent  = btb_q[lk_idx];
    assign upd_ent = btb_q[upd_idx];

    assign bp.pred_hit    = lk_ent.valid && (lk_ent.tag == pc_tag(bp.if_pc, IDX_W));
    assign bp.pred_taken  = bp.pred_hit && (lk_ent.is_jump || lk_ctr[1]);
    assign bp.pred_target = bp.pred_taken ? lk_ent.target : bp.if_pc + 32'd4;

    bp_pht #(
        .ENTRIES (BTB_ENTRIES),
        .GHR_W   (GHR_W)
    ) u_pht (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_pc_idx_i  (lk_idx),
        .upd_en_i     (bp.upd_valid && !bp.upd_is_jump),
        .upd_pc_idx_i (upd_idx),
        .upd_taken_i  (bp.upd_taken),
        .rd_ctr_o     (lk_ctr)
    );

    assign upd_hit = upd_ent.valid && (upd_ent.tag == pc_tag(bp.upd_pc, IDX_W));
    // A not-taken miss never allocates; a taken miss evicts whatever sits at the index.
    assign upd_we  = bp.upd_valid && (upd_hit || bp.upd_taken);

    always_comb begin
        upd_ent_d = upd_ent;
        if (upd_hit) begin
            upd_ent_d.is_jump = bp.upd_is_jump;
            if (bp.upd_taken) begin
                upd_ent_d.target = bp.upd_target;
            end
        end else begin
            upd_ent_d.valid   = 1'b1;
            upd_ent_d.is_jump = bp.upd_is_jump;
            upd_ent_d.tag     = pc_tag(bp.upd_pc, IDX_W);
            upd_ent_d.target  = bp.upd_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_q[i] <= '0;
            end
        end else if (upd_we) begin
            btb_q[upd_idx] <= upd_ent_d;
        end
    end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor (default bimodal build, 64 entries).
module tb_branch_target_predictor;

    logic clk;
    logic rst_n;
    int   vecs;
    int   fails;

    branch_target_predictor_if bp_if ();

    branch_target_predictor #(
        .BTB_ENTRIES (64),
        .GHR_W       (6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bp_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one training pulse spanning exactly one posedge.
    task automatic do_upd(input logic [31:0] pc, input logic jump, input logic taken,
                          input logic [31:0] tgt);
        @(negedge clk);
        bp_if.upd_valid   = 1'b1;
        bp_if.upd_pc      = pc;
        bp_if.upd_is_jump = jump;
        bp_if.upd_taken   = taken;
        bp_if.upd_target  = tgt;
        @(posedge clk);
        #1;
        bp_if.upd_valid = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc);
        @(negedge clk);
        bp_if.if_pc = pc;
        #1;
    endtask

    task automatic test_reset;
        look(32'h60);
        vecs++;
        if ({bp_if.pred_hit, bp_if.pred_taken, bp_if.pred_target} !== {2'b00, 32'h64}) begin
            fails++;
            $display("FAIL reset_0x60: got hit=%b tk=%b tgt=%h want 0 0 00000064",
                     bp_if.pred_hit, bp_if.pred_taken, bp_if.pred_target);
        end
        look(32'hFFFF_FFFC);
        vecs++;
        if ({bp_if.pred_hit, bp_if.pred_taken, bp_if.pred_target} !== {2'b00, 32'h0}) begin
            fails++;
            $display("FAIL reset_wrap: got hit=%b tk=%b tgt=%h want 0 0 00000000",
                     bp_if.pred_hit, bp_if.pred_taken, bp_if.pred_target);
        end
    endtask

    task automatic test_train;
        do_upd(32'h60, 1'b0, 1'b1, 32'h80);
        look(32'h60);
        vecs++;
        if ({bp_if.pred_hit, bp_if.pred_taken, bp_if.pred_target} !== {2'b11, 32'h80}) begin
            fails++;
            $display("FAIL train_taken: got hit=%b tk=%b tgt=%h want 1 1 00000080",
                     bp_if.pred_hit, bp_if.pred_taken, bp_if.pred_target);
        end
        do_upd(32'h40, 1'b0, 1'b0, 32'h90);
        look(32'h40);
        vecs++;
        if ({bp_if.pred_hit, bp_if.pred_taken, bp_if.pred_target} !== {2'b00, 32'h44}) begin
            fails++;
            $display("FAIL nt_no_alloc: got hit=%b tk=%b tgt=%h want 0 0 00000044",
                     bp_if.pred_hit, bp_if.pred_taken, bp_if.pred_target);
        end
    endtask

    task automatic test_saturate;
        do_upd(32'h60, 1'b0, 1'b0, 32'h64);
        look(32'h60);
        vecs++;
        if ({bp_if.pred_hit, bp_if.pred_taken, bp_if.pred_target} !== {2'b10, 32'h64}) begin
            fails++;
            $display("FAIL ctr_01: got hit=%b tk=%b tgt=%h want 1 0 00000064",
                     bp_if.pred_hit, bp_if.pred_taken, bp_if.pred_target);
        end
        do_upd(32'h60, 1'b0, 1'b0, 32'h64);
        do_upd(32'h60, 1'b0, 1'b0, 32'h64);
        look(32'h60);
        vecs++;
        if ({bp_if.pred_hit, bp_if.pred_taken, bp_if.pred_target} !== {2'b10, 32'h64}) begin
            fails++;
            $display("FAIL ctr_sat_low: got hit=%b tk=%b tgt=%h want 1 0 00000064",
                     bp_if.pred_hit, bp_if.pred_taken, bp_if.pred_target);
        end
        do_upd(32'h60, 1'b0, 1'b1, 32'h84);
        look(32'h60);
        vecs++;
        if ({bp_if.pred_hit, bp_if.pred_taken, bp_if.pred_target} !== {2'b10, 32'h64}) begin
            fails++;
            $display("FAIL ctr_00_to_01: got hit=%b tk=%b tgt=%h want 1 0 00000064",
                     bp_if.pred_hit, bp_if.pred_taken, bp_if.pred_target);
        end
        do_upd(32'h60, 1'b0, 1'b1, 32'h84);
        look(32'h60);
        vecs++;
        if ({bp_if.pred_hit, bp_if.pred_taken, bp_if.pred_target} !== {2'b11, 32'h84}) begin
            fails++;
            $display("FAIL retarget: got hit=%b tk=%b tgt=%h want 1 1 00000084",
                     bp_if.pred_hit, bp_if.pred_taken, bp_if.pred_target);
        end
    endtask

    task automatic test_jump;
        do_upd(32'h100, 1'b1, 1'b1, 32'h200);
        look(32'h100);
        vecs++;
        if ({bp_if.pred_hit, bp_if.pred_taken, bp_if.pred_target} !== {2'b11, 32'h200}) begin
            fails++;
            $display("FAIL jump_taken: got hit=%b tk=%b tgt=%h want 1 1 00000200",
                     bp_if.pred_hit, bp_if.pred_taken, bp_if.pred_target);
        end
        // Counter must still be 01: NT gives 00, then taken gives 01 (not taken).
        do_upd(32'h100, 1'b0, 1'b0, 32'h104);
        do_upd(32'h100, 1'b0, 1'b1, 32'h200);
        look(32'h100);
        vecs++;
        if ({bp_if.pred_hit, bp_if.pred_taken, bp_if.pred_target} !== {2'b10, 32'h104}) begin
            fails++;
            $display("FAIL jump_no_pht: got hit=%b tk=%b tgt=%h want 1 0 00000104",
                     bp_if.pred_hit, bp_if.pred_taken, bp_if.pred_target);
        end
    endtask

    task automatic test_alias;
        do_upd(32'h160, 1'b0, 1'b1, 32'h300);
        look(32'h160);
        vecs++;
        if ({bp_if.pred_hit, bp_if.pred_taken, bp_if.pred_target} !== {2'b11, 32'h300}) begin
            fails++;
            $display("FAIL alias_new: got hit=%b tk=%b tgt=%h want 1 1 00000300",
                     bp_if.pred_hit, bp_if.pred_taken, bp_if.pred_target);
        end
        look(32'h60);
        vecs++;
        if ({bp_if.pred_hit, bp_if.pred_taken, bp_if.pred_target} !== {2'b00, 32'h64}) begin
            fails++;
            $display("FAIL alias_evicted: got hit=%b tk=%b tgt=%h want 0 0 00000064",
                     bp_if.pred_hit, bp_if.pred_taken, bp_if.pred_target);
        end
    endtask

    task automatic test_same_cycle;
        @(negedge clk);
        bp_if.if_pc       = 32'h160;
        bp_if.upd_valid   = 1'b1;
        bp_if.upd_pc      = 32'h160;
        bp_if.upd_is_jump = 1'b0;
        bp_if.upd_taken   = 1'b1;
        bp_if.upd_target  = 32'h400;
        #1;
        vecs++;
        if ({bp_if.pred_hit, bp_if.pred_taken, bp_if.pred_target} !== {2'b11, 32'h300}) begin
            fails++;
            $display("FAIL same_cycle_old: got hit=%b tk=%b tgt=%h want 1 1 00000300",
                     bp_if.pred_hit, bp_if.pred_taken, bp_if.pred_target);
        end
        @(posedge clk);
        #1;
        bp_if.upd_valid = 1'b0;
        vecs++;
        if ({bp_if.pred_hit, bp_if.pred_taken, bp_if.pred_target} !== {2'b11, 32'h400}) begin
            fails++;
            $display("FAIL same_cycle_new: got hit=%b tk=%b tgt=%h want 1 1 00000400",
                     bp_if.pred_hit, bp_if.pred_taken, bp_if.pred_target);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        bp_if.upd_valid   = 1'b1;
        bp_if.upd_pc      = 32'h100;
        bp_if.upd_is_jump = 1'b1;
        bp_if.upd_taken   = 1'b1;
        bp_if.upd_target  = 32'h500;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        bp_if.upd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        look(32'h160);
        vecs++;
        if ({bp_if.pred_hit, bp_if.pred_taken, bp_if.pred_target} !== {2'b00, 32'h164}) begin
            fails++;
            $display("FAIL rst_mid_160: got hit=%b tk=%b tgt=%h want 0 0 00000164",
                     bp_if.pred_hit, bp_if.pred_taken, bp_if.pred_target);
        end
        look(32'h100);
        vecs++;
        if ({bp_if.pred_hit, bp_if.pred_taken, bp_if.pred_target} !== {2'b00, 32'h104}) begin
            fails++;
            $display("FAIL rst_mid_100: got hit=%b tk=%b tgt=%h want 0 0 00000104",
                     bp_if.pred_hit, bp_if.pred_taken, bp_if.pred_target);
        end
        // Index 24 counter sat at 11 before reset; a fresh 01 gives 10 then 01 here.
        do_upd(32'h60, 1'b0, 1'b1, 32'h80);
        do_upd(32'h60, 1'b0, 1'b0, 32'h64);
        look(32'h60);
        vecs++;
        if ({bp_if.pred_hit, bp_if.pred_taken, bp_if.pred_target} !== {2'b10, 32'h64}) begin
            fails++;
            $display("FAIL rst_pht_init: got hit=%b tk=%b tgt=%h want 1 0 00000064",
                     bp_if.pred_hit, bp_if.pred_taken, bp_if.pred_target);
        end
    endtask

    initial begin
        vecs              = 0;
        fails             = 0;
        rst_n             = 1'b0;
        bp_if.if_pc       = '0;
        bp_if.upd_valid   = 1'b0;
        bp_if.upd_pc      = '0;
        bp_if.upd_is_jump = 1'b0;
        bp_if.upd_taken   = 1'b0;
        bp_if.upd_target  = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_train();
        test_saturate();
        test_jump();
        test_alias();
        test_same_cycle();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
